riscv_divx: RTL and testbench

Parametrised radix-2^k iterative integer divider for the EX stage. It is the successor to the single-radix divider. It executes DIV/DIVU/REM/REMU, plus the RV64 word forms when XLEN=64, and retires bits-per-cycle digits in each iteration. Divide-by-zero and signed overflow take a single-cycle fast path, and a quotient/remainder reuse cache serves back-to-back DIV/REM pairs on the same operands. The EX stage merges div_r, div_bubble and div_stall into its result, bubble and stall outputs.

---
 rtl/riscv_divx.sv | 234 +++++++++++++++++++++++
 tb/tb_riscv_divx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/riscv_divx.sv
// Radix-2^k iterative integer divider for the EX stage: DIV/DIVU/REM/REMU plus RV64 word forms,
// with a single-cycle fast path for divide-by-zero, signed overflow and last-operand reuse hits.
module riscv_divx #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int HAS_REUSE      = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            div_start,
  input  logic [1:0]      div_op,
  input  logic            div_word,
  input  logic [XLEN-1:0] div_opA,
  input  logic [XLEN-1:0] div_opB,
  input  logic            div_flush,
  output logic            div_stall,
  output logic            div_bubble,
  output logic [XLEN-1:0] div_r
);

  localparam int K        = BITS_PER_CYCLE;
  localparam int CW       = $clog2(XLEN + 1);
  localparam int NUM_MULT = 1 << K;
  localparam logic [XLEN-1:0] ONES = '1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  function automatic logic [XLEN-1:0] ext_word(input logic [XLEN-1:0] x, input logic sgn);
    logic [XLEN-1:0] y;
    y = x;
    for (int i = 32; i < XLEN; i++) y[i] = sgn & x[31];
    return y;
  endfunction

  function automatic logic [XLEN-1:0] fin_word(input logic [XLEN-1:0] x, input logic w);
    return w ? ext_word(x, 1'b1) : x;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] shift_q, shift_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            rem_op_q, rem_op_d;
  logic            word_q, word_d;
  logic            signed_q, signed_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] div_r_q, div_r_d;
  logic            cache_valid_q, cache_valid_d;
  logic [XLEN-1:0] cache_a_q, cache_a_d;
  logic [XLEN-1:0] cache_b_q, cache_b_d;
  logic            cache_signed_q, cache_signed_d;
  logic            cache_word_q, cache_word_d;
  logic [XLEN-1:0] cache_quo_q, cache_quo_d;
  logic [XLEN-1:0] cache_rem_q, cache_rem_d;

  // Operand decode for the launching cycle
  logic            op_signed, op_rem, word_eff;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, most_neg;
  logic            a_neg, b_neg, div_zero, overflow, hit;

  always_comb begin
    op_signed = ~div_op[0];
    op_rem    = div_op[1];
    word_eff  = (XLEN == 64) ? div_word : 1'b0;
    a_ext     = word_eff ? ext_word(div_opA, op_signed) : div_opA;
    b_ext     = word_eff ? ext_word(div_opB, op_signed) : div_opB;
    a_neg     = op_signed & a_ext[XLEN-1];
    b_neg     = op_signed & b_ext[XLEN-1];
    abs_a     = a_neg ? -a_ext : a_ext;
    abs_b     = b_neg ? -b_ext : b_ext;
    most_neg  = word_eff ? (ONES << 31) : (ONES << (XLEN - 1));
    div_zero  = (b_ext == '0);
    overflow  = op_signed & (a_ext == most_neg) & (b_ext == ONES);
    hit       = (HAS_REUSE != 0) & cache_valid_q & (cache_a_q == div_opA) &
                (cache_b_q == div_opB) & (cache_signed_q == op_signed) &
                (cache_word_q == word_eff);
  end

  // One restoring step: largest digit d with d*divisor <= shifted partial remainder
  logic [XLEN+K-1:0] r_shift;
  logic [XLEN+K-1:0] mult [NUM_MULT];
  logic [K-1:0]      digit;
  logic [XLEN-1:0]   rem_next;

  always_comb begin
    r_shift = {rem_q, shift_q[XLEN-1 -: K]};
    digit   = '0;
    for (int i = 0; i < NUM_MULT; i++) begin
      mult[i] = {{K{1'b0}}, dvs_q} * (XLEN + K)'(i);
    end
    for (int i = 1; i < NUM_MULT; i++) begin
      if (mult[i] <= r_shift) digit = K'(i);
    end
    rem_next = XLEN'(r_shift - mult[digit]);
  end

  logic [XLEN-1:0] q_fix, r_fix;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    rem_d          = rem_q;
    dvs_d          = dvs_q;
    qneg_d         = qneg_q;
    rneg_d         = rneg_q;
    rem_op_d       = rem_op_q;
    word_d         = word_q;
    signed_d       = signed_q;
    a_d            = a_q;
    b_d            = b_q;
    div_r_d        = div_r_q;
    cache_valid_d  = cache_valid_q;
    cache_a_d      = cache_a_q;
    cache_b_d      = cache_b_q;
    cache_signed_d = cache_signed_q;
    cache_word_d   = cache_word_q;
    cache_quo_d    = cache_quo_q;
    cache_rem_d    = cache_rem_q;
    q_fix          = fin_word(qneg_q ? -shift_q : shift_q, word_q);
    r_fix          = fin_word(rneg_q ? -rem_q : rem_q, word_q);

    if (div_flush) begin
      state_d       = IDLE;
      cache_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (div_start) begin
            if (div_zero) begin
              div_r_d = op_rem ? fin_word(a_ext, word_eff) : ONES;
              state_d = DONE;
            end else if (overflow) begin
              div_r_d = op_rem ? '0 : fin_word(a_ext, word_eff);
              state_d = DONE;
            end else if (hit) begin
              div_r_d = op_rem ? cache_rem_q : cache_quo_q;
              state_d = DONE;
            end else begin
              // Operand conditioning happens on the launching edge so the first digit retires in cycle 1
              state_d  = ITER;
              cnt_d    = word_eff ? CW'(32 / K) : CW'(XLEN / K);
              shift_d  = word_eff ? (abs_a << (XLEN - 32)) : abs_a;
              rem_d    = '0;
              dvs_d    = abs_b;
              qneg_d   = a_neg ^ b_neg;
              rneg_d   = a_neg;
              rem_op_d = op_rem;
              word_d   = word_eff;
              signed_d = op_signed;
              a_d      = div_opA;
              b_d      = div_opB;
            end
          end
        end
        ITER: begin
          shift_d = {shift_q[XLEN-K-1:0], digit};
          rem_d   = rem_next;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
        FIX: begin
          div_r_d        = rem_op_q ? r_fix : q_fix;
          cache_valid_d  = (HAS_REUSE != 0);
          cache_a_d      = a_q;
          cache_b_d      = b_q;
          cache_signed_d = signed_q;
          cache_word_d   = word_q;
          cache_quo_d    = q_fix;
          cache_rem_d    = r_fix;
          state_d        = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      rem_q          <= '0;
      dvs_q          <= '0;
      qneg_q         <= 1'b0;
      rneg_q         <= 1'b0;
      rem_op_q       <= 1'b0;
      word_q         <= 1'b0;
      signed_q       <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      div_r_q        <= '0;
      cache_valid_q  <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_signed_q <= 1'b0;
      cache_word_q   <= 1'b0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      rem_q          <= rem_d;
      dvs_q          <= dvs_d;
      qneg_q         <= qneg_d;
      rneg_q         <= rneg_d;
      rem_op_q       <= rem_op_d;
      word_q         <= word_d;
      signed_q       <= signed_d;
      a_q            <= a_d;
      b_q            <= b_d;
      div_r_q        <= div_r_d;
      cache_valid_q  <= cache_valid_d;
      cache_a_q      <= cache_a_d;
      cache_b_q      <= cache_b_d;
      cache_signed_q <= cache_signed_d;
      cache_word_q   <= cache_word_d;
      cache_quo_q    <= cache_quo_d;
      cache_rem_q    <= cache_rem_d;
    end
  end

  assign div_stall  = (div_start & (state_q == IDLE) & ~div_flush) |
                      (state_q == ITER) | (state_q == FIX);
  assign div_bubble = (state_q != DONE);
  assign div_r      = div_r_q;

endmodule

// File: tb/tb_riscv_divx.sv
// Directed bench for riscv_divx: a 32-bit radix-2 pair (with and without reuse cache)
// sharing stimulus, plus a 64-bit radix-16 instance for word forms and 64-bit latency.
module tb_riscv_divx;

   logic clk = 1'b0;
   logic rstn;

   // Shared inputs of the two 32-bit instances
   logic        s32Start, s32Flush;
   logic [1:0]  s32Op;
   logic [31:0] s32A, s32B;
   logic        stallR, bubR, stallN, bubN;
   logic [31:0] rR, rN;

   // Inputs of the 64-bit instance
   logic        s64Start, s64Word, s64Flush;
   logic [1:0]  s64Op;
   logic [63:0] s64A, s64B;
   logic        stall64, bub64;
   logic [63:0] r64;

   int errorCount = 0;
   int checkCount = 0;

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   riscv_divx #(.XLEN(32), .BITS_PER_CYCLE(1), .HAS_REUSE(1)) dutReuse (
      .clk(clk), .rstn(rstn), .div_start(s32Start), .div_op(s32Op), .div_word(1'b0),
      .div_opA(s32A), .div_opB(s32B), .div_flush(s32Flush),
      .div_stall(stallR), .div_bubble(bubR), .div_r(rR));

   riscv_divx #(.XLEN(32), .BITS_PER_CYCLE(1), .HAS_REUSE(0)) dutNoReuse (
      .clk(clk), .rstn(rstn), .div_start(s32Start), .div_op(s32Op), .div_word(1'b0),
      .div_opA(s32A), .div_opB(s32B), .div_flush(s32Flush),
      .div_stall(stallN), .div_bubble(bubN), .div_r(rN));

   riscv_divx #(.XLEN(64), .BITS_PER_CYCLE(4), .HAS_REUSE(1)) dut64 (
      .clk(clk), .rstn(rstn), .div_start(s64Start), .div_op(s64Op), .div_word(s64Word),
      .div_opA(s64A), .div_opB(s64B), .div_flush(s64Flush),
      .div_stall(stall64), .div_bubble(bub64), .div_r(r64));

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Launches one operation on both 32-bit instances, optionally flushes it in cycle flushAt,
   // then watches 40 cycles for the result cycle, bubble-low count and stall-high count
   task automatic applyStimulus32(input string tag, input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input int flushAt, input logic [31:0] expR,
                                  input int expLatR, input int expLatN);
      int latR = -1, latN = -1, lowsR = 0, lowsN = 0, stallsR = 0, stallsN = 0;
      @(negedge clk);
      s32Op = op; s32A = a; s32B = b; s32Start = 1'b1;
      #1;
      if (stallR) stallsR++;
      if (stallN) stallsN++;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         s32Start = 1'b0;
         s32Flush = (c == flushAt);
         if (!bubR) begin lowsR++; if (latR < 0) latR = c; end
         if (!bubN) begin lowsN++; if (latN < 0) latN = c; end
         if (stallR) stallsR++;
         if (stallN) stallsN++;
      end
      s32Flush = 1'b0;
      checkOutput({tag, " reuse r"}, 64'(rR), 64'(expR));
      checkOutput({tag, " noreuse r"}, 64'(rN), 64'(expR));
      checkOutput({tag, " reuse latency"}, 64'(latR), 64'(expLatR));
      checkOutput({tag, " noreuse latency"}, 64'(latN), 64'(expLatN));
      checkOutput({tag, " reuse bubble-low cycles"}, 64'(lowsR), (expLatR < 0) ? 64'd0 : 64'd1);
      checkOutput({tag, " noreuse bubble-low cycles"}, 64'(lowsN), (expLatN < 0) ? 64'd0 : 64'd1);
      checkOutput({tag, " reuse stall cycles"}, 64'(stallsR), (flushAt > 0) ? 64'(flushAt + 1) : 64'(expLatR));
      checkOutput({tag, " noreuse stall cycles"}, 64'(stallsN), (flushAt > 0) ? 64'(flushAt + 1) : 64'(expLatN));
   endtask

   // Same idea for the 64-bit radix-16 instance
   task automatic applyStimulus64(input string tag, input logic [1:0] op, input logic word,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] expR, input int expLat);
      int lat = -1, lows = 0, stalls = 0;
      @(negedge clk);
      s64Op = op; s64Word = word; s64A = a; s64B = b; s64Start = 1'b1;
      #1;
      if (stall64) stalls++;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         s64Start = 1'b0;
         if (!bub64) begin lows++; if (lat < 0) lat = c; end
         if (stall64) stalls++;
      end
      checkOutput({tag, " r"}, r64, expR);
      checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
      checkOutput({tag, " bubble-low cycles"}, 64'(lows), 64'd1);
      checkOutput({tag, " stall cycles"}, 64'(stalls), 64'(expLat));
   endtask

   // Main sequence: reset checks, 32-bit directed vectors, then 64-bit vectors
   initial begin
      rstn = 1'b0;
      s32Start = 1'b0; s32Flush = 1'b0; s32Op = 2'b00; s32A = '0; s32B = '0;
      s64Start = 1'b0; s64Flush = 1'b0; s64Word = 1'b0; s64Op = 2'b00; s64A = '0; s64B = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset r32", 64'(rR), 64'd0);
      checkOutput("reset bubble32", 64'(bubR), 64'd1);
      checkOutput("reset stall32", 64'(stallR), 64'd0);
      checkOutput("reset r64", r64, 64'd0);
      checkOutput("reset bubble64", 64'(bub64), 64'd1);
      checkOutput("reset stall64", 64'(stall64), 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      applyStimulus32("DIV -7/2",       2'b00, 32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFD, 34, 34);
      applyStimulus32("REM -7/2",       2'b10, 32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFF,  1, 34);
      applyStimulus32("DIV 7/-2",       2'b00, 32'd7,        32'hFFFFFFFE, 0, 32'hFFFFFFFD, 34, 34);
      applyStimulus32("DIVU 5/0",       2'b01, 32'd5,        32'd0,        0, 32'hFFFFFFFF,  1,  1);
      applyStimulus32("REM 5/0",        2'b10, 32'd5,        32'd0,        0, 32'h00000005,  1,  1);
      applyStimulus32("DIV ovf",        2'b00, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000,  1,  1);
      applyStimulus32("REM ovf",        2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 32'h00000000,  1,  1);
      applyStimulus32("DIV 100/7",      2'b00, 32'd100,      32'd7,        0, 32'd14,       34, 34);
      applyStimulus32("REM 100/7 hit",  2'b10, 32'd100,      32'd7,        0, 32'd2,         1, 34);
      applyStimulus32("DIVU flushed",   2'b01, 32'd1000,     32'd3,       10, 32'd2,        -1, -1);
      applyStimulus32("REM 100/7 miss", 2'b10, 32'd100,      32'd7,        0, 32'd2,        34, 34);
      applyStimulus32("REM 1000/3",     2'b10, 32'd1000,     32'd3,        0, 32'd1,        34, 34);

      applyStimulus64("DIVW -8/2",  2'b00, 1'b1, 64'h00000000FFFFFFF8, 64'd2,  64'hFFFFFFFFFFFFFFFC, 10);
      applyStimulus64("DIVU 64",    2'b01, 1'b0, 64'h0123456789ABCDEF, 64'h10, 64'h00123456789ABCDE, 18);
      applyStimulus64("REMU 64 hit", 2'b11, 1'b0, 64'h0123456789ABCDEF, 64'h10, 64'h000000000000000F, 1);
      applyStimulus64("REMW -7/2",  2'b10, 1'b1, 64'h00000000FFFFFFF9, 64'd2,  64'hFFFFFFFFFFFFFFFF, 10);
      applyStimulus64("DIVUW sext", 2'b01, 1'b1, 64'hFFFFFFFF80000000, 64'd1,  64'hFFFFFFFF80000000, 10);
      applyStimulus64("DIV -100/7", 2'b00, 1'b0, 64'hFFFFFFFFFFFFFF9C, 64'd7,  64'hFFFFFFFFFFFFFFF2, 18);
      applyStimulus64("DIVUW 5/0",  2'b01, 1'b1, 64'd5,                64'd0,  64'hFFFFFFFFFFFFFFFF, 1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
